// File: rtl/noc_pkg.sv
// Shared NoC definitions: flit types, output directions, coordinates
// and input-port states.
package noc_pkg;

  localparam logic [1:0] TYPE_BODY   = 2'b00;
  localparam logic [1:0] TYPE_HEAD   = 2'b01;
  localparam logic [1:0] TYPE_TAIL   = 2'b10;
  localparam logic [1:0] TYPE_SINGLE = 2'b11;

  localparam int DIR_LOCAL = 0;
  localparam int DIR_SOUTH = 1;
  localparam int DIR_NORTH = 2;
  localparam int DIR_WEST  = 3;

  localparam logic [3:0] OH_LOCAL = 4'b0001;
  localparam logic [3:0] OH_SOUTH = 4'b0010;
  localparam logic [3:0] OH_NORTH = 4'b0100;
  localparam logic [3:0] OH_WEST  = 4'b1000;

  localparam int COORD_W = 2;
  localparam int Y_LSB   = 0;
  localparam int X_LSB   = 2;

  typedef enum logic [1:0] {
    IDLE,
    ROUTE,
    ACTIVE,
    DROP
  } port_state_e;

  // Head and single open a packet; tail and single close it.
  function automatic logic opens(input logic [1:0] t);
    return t[0];
  endfunction

  function automatic logic closes(input logic [1:0] t);
    return t[1];
  endfunction

  // East edge router: a larger column has no output, so it maps to 0.
  function automatic logic [3:0] route_of(
    input logic [COORD_W-1:0] dx,
    input logic [COORD_W-1:0] dy,
    input logic [COORD_W-1:0] mx,
    input logic [COORD_W-1:0] my
  );
    logic [3:0] r;
    r = '0;
    unique case (1'b1)
      (dx > mx):               r = '0;
      (dx < mx):               r = OH_WEST;
      (dx == mx && dy > my):   r = OH_NORTH;
      (dx == mx && dy < my):   r = OH_SOUTH;
      default:                 r = OH_LOCAL;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/noc_input_port_fifo.sv
// Flit FIFO with power-of-two depth; refuses pushes while full even
// when a pop happens in the same cycle.
module flit_fifo #(
  parameter int WIDTH = 18,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic                       pop,
  input  logic [WIDTH-1:0]           wdata,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count,
  output logic [WIDTH-1:0]           head
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    rd_ptr;
  logic [AW-1:0]    wr_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

endmodule

// File: rtl/noc_input_port.sv
// Router input port: buffers flits, routes the head flit and requests
// one output arbiter until the tail flit has been granted.
module noc_input_port
  import noc_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int DEPTH  = 4,
  parameter int MY_X   = 0,
  parameter int MY_Y   = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W+1:0] in_flit,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [3:0]        grant,
  output logic [3:0]        req,
  output logic [DATA_W+1:0] out_flit,
  output logic              out_valid,
  output logic              err_drop
);

  localparam int FW = DATA_W + 2;
  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [COORD_W-1:0] MX = COORD_W'(MY_X);
  localparam logic [COORD_W-1:0] MY = COORD_W'(MY_Y);

  logic [FW-1:0] head;
  logic          full;
  logic          empty;
  logic [CW-1:0] count;
  logic          push;
  logic          pop;
  logic [1:0]    head_type;
  logic [1:0]    in_type;
  logic [3:0]    head_route;
  logic [3:0]    route;
  port_state_e   state;

  assign in_ready  = (count != CW'(DEPTH));
  assign push      = in_valid && !full;
  assign head_type = head[FW-1 -: 2];
  assign in_type   = in_flit[FW-1 -: 2];
  assign head_route = route_of(head[X_LSB +: COORD_W],
                               head[Y_LSB +: COORD_W], MX, MY);

  assign req       = (state == ACTIVE && !empty) ? route : '0;
  assign out_valid = |(req & grant);
  assign out_flit  = head;

  always_comb begin
    pop = 1'b0;
    unique case (state)
      IDLE:    pop = !empty && !opens(head_type);
      ACTIVE:  pop = out_valid;
      DROP:    pop = !empty;
      default: pop = 1'b0;
    endcase
  end

  flit_fifo #(
    .WIDTH (FW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .wdata (in_flit),
    .full  (full),
    .empty (empty),
    .count (count),
    .head  (head)
  );

  // An empty IDLE port looks at the arriving flit so ROUTE follows the push.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      route    <= '0;
      err_drop <= 1'b0;
    end else begin
      err_drop <= 1'b0;
      unique case (state)
        IDLE: begin
          if (!empty) begin
            if (opens(head_type)) begin
              state <= ROUTE;
            end else begin
              err_drop <= 1'b1;
            end
          end else if (push && opens(in_type)) begin
            state <= ROUTE;
          end
        end
        ROUTE: begin
          route <= head_route;
          if (head_route == '0) begin
            state    <= DROP;
            err_drop <= 1'b1;
          end else begin
            state <= ACTIVE;
          end
        end
        ACTIVE, DROP: begin
          if (pop && closes(head_type)) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_noc_input_port.sv
// Directed and randomized checks of noc_input_port at router (1,1)
// against a packet-level routing and ordering model.
module tb_noc_input_port;

  localparam logic [1:0] T_BODY   = 2'b00;
  localparam logic [1:0] T_HEAD   = 2'b01;
  localparam logic [1:0] T_TAIL   = 2'b10;
  localparam logic [1:0] T_SINGLE = 2'b11;

  typedef struct {
    logic [17:0] f;
    logic [3:0]  d;
  } exp_t;

  logic        clk;
  logic        rst;
  logic [17:0] in_flit;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  grant;
  logic [3:0]  req;
  logic [17:0] out_flit;
  logic        out_valid;
  logic        err_drop;
  logic [3:0]  gen;
  logic [3:0]  gextra;

  int passed;
  int total;
  int drops_seen;
  int drops_exp;

  exp_t        expq[$];
  logic [17:0] src[$];
  logic [17:0] f[4];

  assign grant = (req & gen) | gextra;

  noc_input_port #(
    .DATA_W (16),
    .DEPTH  (4),
    .MY_X   (1),
    .MY_Y   (1)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_flit   (in_flit),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .grant     (grant),
    .req       (req),
    .out_flit  (out_flit),
    .out_valid (out_valid),
    .err_drop  (err_drop)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [17:0] mk(input logic [1:0] t,
                                     input logic [15:0] p);
    return {t, p};
  endfunction

  function automatic logic [3:0] model_dir(input int dx, input int dy);
    if (dx > 1) return 4'b0000;
    if (dx < 1) return 4'b1000;
    if (dy > 1) return 4'b0100;
    if (dy < 1) return 4'b0010;
    return 4'b0001;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
    if (err_drop) drops_seen++;
    if (req == 4'b0 && grant != 4'b0) check("ignored_grant", out_valid, 0);
    if (req != 4'b0) begin
      if (expq.size() == 0) check("req_spurious", req, 0);
      else check("req_dir", req, expq[0].d);
    end
    if (out_valid) begin
      if (expq.size() == 0) begin
        check("out_unexpected", out_valid, 0);
      end else begin
        check("out_flit", out_flit, expq[0].f);
        void'(expq.pop_front());
      end
    end
  endtask

  task automatic add_pkt(input logic [3:0] d);
    for (int i = 0; i < 4; i++) expq.push_back('{f: f[i], d: d});
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    passed = 0; total = 0; drops_seen = 0; drops_exp = 0;
    rst = 1'b1; in_valid = 1'b0; in_flit = '0; gen = '0; gextra = '0;
    nxt();
    smp();
    check("rst_req", req, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_err_drop", err_drop, 0);
    check("rst_in_ready", in_ready, 1);
    nxt();
    rst = 1'b0;
    smp();

    // single flit to local
    nxt();
    in_valid = 1'b1; in_flit = mk(T_SINGLE, 16'h5a05); gen = 4'b0001;
    expq.push_back('{f: in_flit, d: 4'b0001});
    smp();
    check("t1_req_push", req, 0);
    nxt();
    in_valid = 1'b0;
    smp();
    check("t1_req_route", req, 0);
    nxt();
    smp();
    check("t1_req", req, 4'b0001);
    check("t1_out_valid", out_valid, 1);
    nxt();
    smp();
    check("t1_req_after", req, 0);
    check("t1_out_after", out_valid, 0);
    check("t1_drained", expq.size(), 0);

    // west packet, grant withheld three cycles
    f[0] = mk(T_HEAD, 16'ha002); f[1] = mk(T_BODY, 16'hb001);
    f[2] = mk(T_BODY, 16'hb002); f[3] = mk(T_TAIL, 16'hc003);
    add_pkt(4'b1000);
    gen = '0;
    for (int i = 0; i < 4; i++) begin
      nxt();
      in_valid = 1'b1; in_flit = f[i];
      smp();
      if (i >= 2) begin
        check("t2_hold_req", req, 4'b1000);
        check("t2_hold_ov", out_valid, 0);
      end
    end
    nxt();
    in_valid = 1'b0;
    smp();
    check("t2_hold_req", req, 4'b1000);
    for (int i = 0; i < 4; i++) begin
      nxt();
      gen = 4'b1000;
      smp();
      check("t2_stream_ov", out_valid, 1);
    end
    nxt();
    gen = '0;
    smp();
    check("t2_req_end", req, 0);
    check("t2_drained", expq.size(), 0);

    // north packet, grant every other cycle
    f[0] = mk(T_HEAD, 16'ha006); f[1] = mk(T_BODY, 16'hb011);
    f[2] = mk(T_BODY, 16'hb012); f[3] = mk(T_TAIL, 16'hc013);
    add_pkt(4'b0100);
    for (int k = 0; k < 14; k++) begin
      nxt();
      in_valid = (k < 4);
      if (k < 4) in_flit = f[k];
      gen = k[0] ? 4'b0100 : 4'b0000;
      smp();
      if (gen == 4'b0) check("t3_no_grant", out_valid, 0);
      else if (req != 4'b0) check("t3_grant", out_valid, 1);
    end
    check("t3_drained", expq.size(), 0);

    // illegal destination dropped whole
    f[0] = mk(T_HEAD, 16'ha009); f[1] = mk(T_BODY, 16'hb021);
    f[2] = mk(T_BODY, 16'hb022); f[3] = mk(T_TAIL, 16'hc023);
    drops_exp++;
    gen = 4'b1111;
    for (int k = 0; k < 9; k++) begin
      nxt();
      in_valid = (k < 4);
      if (k < 4) in_flit = f[k];
      smp();
      check("t4_no_req", req, 0);
    end
    check("t4_drop_pulses", drops_seen, drops_exp);
    nxt();
    in_valid = 1'b1; in_flit = mk(T_SINGLE, 16'hd005);
    expq.push_back('{f: in_flit, d: 4'b0001});
    smp();
    for (int k = 0; k < 3; k++) begin
      nxt();
      in_valid = 1'b0;
      smp();
    end
    check("t4_next_routed", expq.size(), 0);

    // full FIFO refuses a fifth flit
    f[0] = mk(T_HEAD, 16'ha001); f[1] = mk(T_BODY, 16'hb031);
    f[2] = mk(T_BODY, 16'hb032); f[3] = mk(T_TAIL, 16'hc033);
    add_pkt(4'b1000);
    gen = '0;
    for (int i = 0; i < 4; i++) begin
      nxt();
      in_valid = 1'b1; in_flit = f[i];
      smp();
    end
    nxt();
    in_flit = mk(T_BODY, 16'heeee);
    smp();
    check("t5_full", in_ready, 0);
    nxt();
    gen = 4'b1000;
    smp();
    check("t5_full_pop", in_ready, 0);
    check("t5_pop_ov", out_valid, 1);
    nxt();
    in_valid = 1'b0; gen = '0;
    smp();
    check("t5_ready_again", in_ready, 1);
    for (int k = 0; k < 4; k++) begin
      nxt();
      gen = 4'b1000;
      smp();
    end
    check("t5_drained", expq.size(), 0);

    // reset mid-packet
    f[0] = mk(T_HEAD, 16'ha005); f[1] = mk(T_BODY, 16'hb041);
    f[2] = mk(T_BODY, 16'hb042); f[3] = mk(T_TAIL, 16'hc043);
    add_pkt(4'b0001);
    gen = 4'b0001;
    for (int i = 0; i < 4; i++) begin
      nxt();
      in_valid = 1'b1; in_flit = f[i];
      smp();
    end
    check("t6_two_popped", expq.size(), 2);
    nxt();
    in_valid = 1'b0; gen = '0; rst = 1'b1;
    smp();
    nxt();
    rst = 1'b0; gen = 4'b0001;
    expq.delete();
    smp();
    check("t6_req", req, 0);
    check("t6_in_ready", in_ready, 1);
    nxt();
    smp();
    check("t6_empty", req, 0);
    nxt();
    in_valid = 1'b1; in_flit = mk(T_HEAD, 16'ha105);
    expq.push_back('{f: in_flit, d: 4'b0001});
    smp();
    nxt();
    in_flit = mk(T_TAIL, 16'hc105);
    expq.push_back('{f: in_flit, d: 4'b0001});
    smp();
    for (int k = 0; k < 4; k++) begin
      nxt();
      in_valid = 1'b0;
      smp();
    end
    check("t6_after_reset", expq.size(), 0);
    check("t6_no_drop", drops_seen, drops_exp);

    // randomized packets, strays and grants
    for (int p = 0; p < 40; p++) begin
      int dx, dy, len;
      logic [3:0] d;
      if ($urandom_range(0, 5) == 0) begin
        src.push_back(mk($urandom_range(0, 1) ? T_TAIL : T_BODY,
                         16'($urandom)));
        drops_exp++;
      end
      dx = $urandom_range(0, 3);
      dy = $urandom_range(0, 3);
      len = $urandom_range(1, 5);
      d = model_dir(dx, dy);
      for (int i = 0; i < len; i++) begin
        logic [1:0]  t;
        logic [15:0] pl;
        if (len == 1) t = T_SINGLE;
        else if (i == 0) t = T_HEAD;
        else if (i == len - 1) t = T_TAIL;
        else t = T_BODY;
        pl = (i == 0) ? {p[7:0], 4'h0, 2'(dx), 2'(dy)} : 16'($urandom);
        src.push_back(mk(t, pl));
        if (d != 4'b0) expq.push_back('{f: mk(t, pl), d: d});
      end
      if (d == 4'b0) drops_exp++;
    end
    for (int c = 0; c < 5000; c++) begin
      if (src.size() == 0 && expq.size() == 0) break;
      nxt();
      in_valid = (src.size() > 0) && ($urandom_range(0, 3) != 0);
      if (src.size() > 0) in_flit = src[0];
      gen = 4'($urandom);
      gextra = ($urandom_range(0, 4) == 0) ? 4'($urandom) : 4'b0;
      smp();
      if (in_valid && in_ready) void'(src.pop_front());
    end
    check("rand_drained", src.size() + expq.size(), 0);
    for (int k = 0; k < 12; k++) begin
      nxt();
      in_valid = 1'b0; gextra = '0;
      smp();
    end
    check("rand_drops", drops_seen, drops_exp);
    check("rand_idle_req", req, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
